pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the fetch path.
// Owns the PC register and picks increment, jump, branch, stall-hold or halt
// each cycle; reports fetch validity, state, a wrap pulse and a fetch count.
module pc_sequencer #(
   parameter int unsigned          PC_WIDTH  = 7,
   parameter logic [PC_WIDTH-1:0]  RESET_VEC = '0,
   parameter int unsigned          STEP      = 1,
   parameter int unsigned          CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 jump,
   input  logic [PC_WIDTH-1:0]  jump_target,
   input  logic                 halt,
   output logic [PC_WIDTH-1:0]  pc_out,
   output logic [PC_WIDTH-1:0]  pc_next,
   output logic                 fetch_valid,
   output logic                 wrap,
   output logic [1:0]           state_out,
   output logic [CNT_WIDTH-1:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_STALL  = 2'b10,
      S_HALTED = 2'b11
   } state_t;

   localparam logic [PC_WIDTH-1:0]  STEP_W  = PC_WIDTH'(STEP);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t              state, state_nx;
   logic [PC_WIDTH-1:0] pc, pc_nx;
   logic [PC_WIDTH:0]   inc_sum;
   logic                incr;

   // Extra top bit captures the carry-out that marks a wrap to zero.
   assign inc_sum = {1'b0, pc} + {1'b0, STEP_W};

   // Next-state / next-PC selection: halt > jump > branch > stall > increment.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      incr     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_RUN;
         end
         S_RUN, S_STALL: begin
            if (halt) begin
               state_nx = S_HALTED;
            end else if (jump) begin
               pc_nx    = jump_target;
               state_nx = S_RUN;
            end else if (branch_taken) begin
               pc_nx    = branch_target;
               state_nx = S_RUN;
            end else if (stall) begin
               state_nx = S_STALL;
            end else if (state == S_RUN) begin
               pc_nx    = inc_sum[PC_WIDTH-1:0];
               incr     = 1'b1;
               state_nx = S_RUN;
            end else begin
               // Release from stall re-fetches the held address.
               state_nx = S_RUN;
            end
         end
         S_HALTED: begin
            state_nx = S_HALTED;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Registered state, PC and status; fetch_valid and the count track the
   // state being entered so they line up with pc_out on the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_VEC;
         fetch_valid <= 1'b0;
         wrap        <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         fetch_valid <= (state_nx == S_RUN);
         wrap        <= incr & inc_sum[PC_WIDTH];
         if ((state_nx == S_RUN) && (fetch_count != '1))
            fetch_count <= fetch_count + CNT_ONE;
      end
   end

   assign pc_out    = pc;
   assign pc_next   = pc_nx;
   assign state_out = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, hand-written reset
// sequences, and randomized stimulus against a behavioural model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, halt = 1'b0;
   logic [6:0]  branch_target = '0, jump_target = '0;
   logic [6:0]  pc_out, pc_next, pc_out2, pc_next2;
   logic        fetch_valid, wrap, fetch_valid2, wrap2;
   logic [1:0]  state_out, state_out2;
   logic [15:0] fetch_count;
   logic [2:0]  fetch_count2;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state (spec encoding: 0 IDLE, 1 RUN, 2 STALL, 3 HALTED).
   int m_pc, m_st, m_cnt, m_wrap;

   pc_sequencer #(.PC_WIDTH(7), .RESET_VEC(7'd0), .STEP(1), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .halt(halt),
      .pc_out(pc_out), .pc_next(pc_next), .fetch_valid(fetch_valid),
      .wrap(wrap), .state_out(state_out), .fetch_count(fetch_count)
   );

   // Narrow-counter copy exposes saturation within a short run.
   pc_sequencer #(.PC_WIDTH(7), .RESET_VEC(7'd0), .STEP(1), .CNT_WIDTH(3)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .halt(halt),
      .pc_out(pc_out2), .pc_next(pc_next2), .fetch_valid(fetch_valid2),
      .wrap(wrap2), .state_out(state_out2), .fetch_count(fetch_count2)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       start, stall, bt;
      bit [6:0] btg;
      bit       j;
      bit [6:0] jt;
      bit       h;
      int       e_pc, e_st, e_fv, e_wrap, e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit s, bit st, bit bt, int btg, bit j, int jt, bit h,
                               int e_pc, int e_st, int e_fv, int e_wrap, int e_cnt);
      vec_t v;
      v.start = s; v.stall = st; v.bt = bt; v.btg = 7'(btg);
      v.j = j; v.jt = 7'(jt); v.h = h;
      v.e_pc = e_pc; v.e_st = e_st; v.e_fv = e_fv; v.e_wrap = e_wrap; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic drive(input bit s, input bit st, input bit bt, input bit [6:0] btg,
                        input bit j, input bit [6:0] jt, input bit h);
      start = s; stall = st; branch_taken = bt; branch_target = btg;
      jump = j; jump_target = jt; halt = h;
   endtask

   task automatic check_outputs(input string tag, input int e_pc, input int e_st,
                                input int e_fv, input int e_wrap, input int e_cnt);
      chk({tag, ".pc_out"}, int'(pc_out), e_pc);
      chk({tag, ".state_out"}, int'(state_out), e_st);
      chk({tag, ".fetch_valid"}, int'(fetch_valid), e_fv);
      chk({tag, ".wrap"}, int'(wrap), e_wrap);
      chk({tag, ".fetch_count"}, int'(fetch_count), min_i(e_cnt, 65535));
      chk({tag, ".fetch_count_sat"}, int'(fetch_count2), min_i(e_cnt, 7));
   endtask

   // Spec-level model: returns what the next cycle should look like.
   task automatic model_next(output int npc, output int nst, output int nwrap);
      npc = m_pc; nst = m_st; nwrap = 0;
      if (m_st == 0) begin
         if (start) nst = 1;
      end else if (m_st == 1 || m_st == 2) begin
         if (halt)              nst = 3;
         else if (jump)         begin npc = jump_target;   nst = 1; end
         else if (branch_taken) begin npc = branch_target; nst = 1; end
         else if (stall)        nst = 2;
         else if (m_st == 1)    begin npc = (m_pc + 1) % 128; nwrap = (m_pc + 1 >= 128); end
         else                   nst = 1;
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_st = 0; m_cnt = 0; m_wrap = 0;
   endtask

   // Called at posedge+1; reset pulse stays clear of the clock edges.
   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_outputs("post_reset", 0, 0, 0, 0, 0);
   endtask

   task automatic rand_cycle();
      int npc, nst, nw;
      drive(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
            (($urandom % 4) == 0) ? 7'd127 : 7'($urandom),
            ($urandom % 6) == 0,
            (($urandom % 4) == 0) ? 7'd125 : 7'($urandom),
            ($urandom % 150) == 0);
      #1;
      model_next(npc, nst, nw);
      chk("rand.pc_next", int'(pc_next), npc);
      @(posedge clk);
      m_pc = npc; m_st = nst; m_wrap = nw;
      if (m_st == 1) m_cnt++;
      #1;
      check_outputs("rand", m_pc, m_st, (m_st == 1), m_wrap, m_cnt);
   endtask

   initial begin
      int halted_cycles;

      // Directed table starting from reset.
      vecs.push_back(mk(0,1,1,9, 1,9, 0,   0,0,0,0, 0));  // IDLE ignores all but start
      vecs.push_back(mk(1,0,0,0, 0,0, 0,   0,1,1,0, 1));  // start: first fetch at 0
      vecs.push_back(mk(0,0,0,0, 0,0, 0,   1,1,1,0, 2));
      vecs.push_back(mk(0,0,0,0, 0,0, 0,   2,1,1,0, 3));
      vecs.push_back(mk(0,0,0,0, 0,0, 0,   3,1,1,0, 4));
      vecs.push_back(mk(0,0,0,0, 0,0, 0,   4,1,1,0, 5));
      vecs.push_back(mk(0,0,0,0, 1,10,0,  10,1,1,0, 6));
      vecs.push_back(mk(0,0,1,20,1,50,0,  50,1,1,0, 7));  // jump beats branch
      vecs.push_back(mk(0,0,0,0, 0,0, 0,  51,1,1,0, 8));
      vecs.push_back(mk(0,0,1,30,0,0, 0,  30,1,1,0, 9));
      vecs.push_back(mk(0,1,0,0, 0,0, 0,  30,2,0,0, 9));
      vecs.push_back(mk(0,1,0,0, 0,0, 0,  30,2,0,0, 9));
      vecs.push_back(mk(0,1,0,0, 0,0, 0,  30,2,0,0, 9));
      vecs.push_back(mk(0,0,0,0, 0,0, 0,  30,1,1,0,10));  // release re-fetches 30
      vecs.push_back(mk(0,0,0,0, 0,0, 0,  31,1,1,0,11));
      vecs.push_back(mk(0,1,0,0, 1,126,0,126,1,1,0,12));  // jump overrides stall
      vecs.push_back(mk(0,0,0,0, 0,0, 0, 127,1,1,0,13));
      vecs.push_back(mk(0,0,0,0, 0,0, 0,   0,1,1,1,14));  // wrap pulse
      vecs.push_back(mk(0,0,0,0, 0,0, 0,   1,1,1,0,15));
      vecs.push_back(mk(0,1,0,0, 0,0, 0,   1,2,0,0,15));
      vecs.push_back(mk(0,1,1,127,0,0,0, 127,1,1,0,16));  // branch out of STALL
      vecs.push_back(mk(0,0,0,0, 1,0, 0,   0,1,1,0,17));  // redirect to 0: no wrap
      vecs.push_back(mk(0,0,0,0, 1,40,0,  40,1,1,0,18));
      vecs.push_back(mk(0,0,1,5, 1,90,1,  40,3,0,0,18));  // halt beats jump
      vecs.push_back(mk(1,0,0,0, 0,0, 0,  40,3,0,0,18));
      vecs.push_back(mk(0,0,1,6, 1,5, 0,  40,3,0,0,18));

      drive(0, 0, 0, 0, 0, 0, 0);
      #12;
      check_outputs("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].start, vecs[i].stall, vecs[i].bt, vecs[i].btg,
               vecs[i].j, vecs[i].jt, vecs[i].h);
         #1;
         chk($sformatf("vec%0d.pc_next", i), int'(pc_next), vecs[i].e_pc);
         @(posedge clk); #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_st,
                       vecs[i].e_fv, vecs[i].e_wrap, vecs[i].e_cnt);
      end

      // Reset out of HALTED.
      do_reset();

      // Asynchronous reset mid-cycle while stalled at 60.
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1, 7'd60, 0);
      @(posedge clk); #1;
      drive(0, 1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_outputs("stall60", 60, 2, 0, 0, 2);
      #2;
      rst = 1'b1;
      #1;
      check_outputs("async_rst", 0, 0, 0, 0, 0);
      #1;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_outputs("async_rst_after", 0, 0, 0, 0, 0);

      // Randomized run against the model.
      do_reset();
      halted_cycles = 0;
      for (int c = 0; c < 3000; c++) begin
         rand_cycle();
         if (m_st == 3) halted_cycles++;
         else           halted_cycles = 0;
         if (halted_cycles > 3 || ($urandom % 400) == 0) begin
            halted_cycles = 0;
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
